// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: arm/trigger/post-capture sequencing and oldest-first dump of a circular trace buffer
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   arm_i, abort_i, force_trig_i       capture control pulses
//   pc_match_en_i, pc_match_i          PC-match trigger
//   post_count_i                       retires to keep after the trigger
//   retire_pulse_i, fetch_pc_i         retire stream
//   buf_wr_ptr_i, buf_rd_*_i           trace buffer write pointer and read data
//   trace_enable_o, trace_trigger_o    buffer write enable and freeze
//   trace_rd_addr_o                    buffer read address
//   dump_start_i, dump_ready_i         dump request and sink backpressure
//   dump_valid_o, dump_pc_o, dump_instr_o, dump_last_o, dump_done_o   dump stream
//   state_o, fill_o, trig_pc_o         status
module trace_capture_ctrl #(
  parameter int TRACE_DEPTH = 64,
  localparam int PTR_BITS = $clog2(TRACE_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic                force_trig_i,
  input  logic                pc_match_en_i,
  input  logic [31:0]         pc_match_i,
  input  logic [PTR_BITS:0]   post_count_i,
  input  logic                retire_pulse_i,
  input  logic [31:0]         fetch_pc_i,
  input  logic [PTR_BITS-1:0] buf_wr_ptr_i,
  input  logic [31:0]         buf_rd_pc_i,
  input  logic [31:0]         buf_rd_instr_i,
  output logic                trace_enable_o,
  output logic                trace_trigger_o,
  output logic [PTR_BITS-1:0] trace_rd_addr_o,
  input  logic                dump_start_i,
  input  logic                dump_ready_i,
  output logic                dump_valid_o,
  output logic [31:0]         dump_pc_o,
  output logic [31:0]         dump_instr_o,
  output logic                dump_last_o,
  output logic                dump_done_o,
  output logic [2:0]          state_o,
  output logic [PTR_BITS:0]   fill_o,
  output logic [31:0]         trig_pc_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, POST = 3'd2, FROZEN = 3'd3, FETCH = 3'd4, SEND = 3'd5} state_e;
  localparam logic [PTR_BITS:0] FULL = TRACE_DEPTH[PTR_BITS:0];
  localparam logic [PTR_BITS:0] ONE = (PTR_BITS+1)'(1);
  state_e state_q, state_d;
  logic [PTR_BITS:0] fill_q, fill_d, rem_q, rem_d;
  logic [PTR_BITS-1:0] start_q, start_d, idx_q, idx_d;
  logic [31:0] trig_pc_q, trig_pc_d, dpc_q, dpc_d, dins_q, dins_d;
  logic done_q, done_d, trig, cap;
  assign trig = force_trig_i | (retire_pulse_i & pc_match_en_i & (fetch_pc_i == pc_match_i));
  assign cap = retire_pulse_i & trace_enable_o;
  assign trace_enable_o = (state_q == ARMED) | ((state_q == POST) & (rem_q != '0));
  assign trace_trigger_o = (state_q == FROZEN) | (state_q == FETCH) | (state_q == SEND);
  assign trace_rd_addr_o = start_q + idx_q;
  assign dump_valid_o = state_q == SEND;
  assign dump_last_o = dump_valid_o & ({1'b0, idx_q} == fill_q - ONE);
  assign dump_pc_o = dpc_q;
  assign dump_instr_o = dins_q;
  assign dump_done_o = done_q;
  assign state_o = state_q;
  assign fill_o = fill_q;
  assign trig_pc_o = trig_pc_q;
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    rem_d = rem_q;
    trig_pc_d = trig_pc_q;
    start_d = start_q;
    idx_d = idx_q;
    dpc_d = dpc_q;
    dins_d = dins_q;
    done_d = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      fill_d = (cap && fill_q != FULL) ? fill_q + ONE : fill_q;
      case (state_q)
        IDLE: if (arm_i) begin
          state_d = ARMED;
          fill_d = '0;
        end
        ARMED: if (trig) begin
          state_d = POST;
          rem_d = post_count_i;
          trig_pc_d = fetch_pc_i;
        end
        POST: begin
          if (rem_q == '0) state_d = FROZEN;
          else if (retire_pulse_i) rem_d = rem_q - ONE;
        end
        FROZEN: begin
          if (arm_i) begin
            state_d = ARMED;
            fill_d = '0;
          end else if (dump_start_i) begin
            if (fill_q == '0) begin
              done_d = 1'b1;
            end else begin
              // oldest valid entry sits fill slots behind the write pointer; a full buffer wraps onto it
              start_d = buf_wr_ptr_i - fill_q[PTR_BITS-1:0];
              idx_d = '0;
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          dpc_d = buf_rd_pc_i;
          dins_d = buf_rd_instr_i;
          state_d = SEND;
        end
        SEND: if (dump_ready_i) begin
          if (dump_last_o) begin
            done_d = 1'b1;
            state_d = FROZEN;
          end else begin
            idx_d = idx_q + PTR_BITS'(1);
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fill_q <= '0;
      rem_q <= '0;
      trig_pc_q <= '0;
      start_q <= '0;
      idx_q <= '0;
      dpc_q <= '0;
      dins_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      rem_q <= rem_d;
      trig_pc_q <= trig_pc_d;
      start_q <= start_d;
      idx_q <= idx_d;
      dpc_q <= dpc_d;
      dins_q <= dins_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: directed and randomized checks of trace_capture_ctrl against a queue-based model
module tb_trace_capture_ctrl;
  localparam int D = 8;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic arm_i = 0, abort_i = 0, force_trig_i = 0, pc_match_en_i = 0, retire_pulse_i = 0;
  logic dump_start_i = 0, dump_ready_i = 1;
  logic [31:0] pc_match_i = 0, fetch_pc_i = 0, instr = 0;
  logic [3:0] post_count_i = 0;
  logic [2:0] buf_wr_ptr_i;
  logic [31:0] buf_rd_pc_i, buf_rd_instr_i;
  logic trace_enable_o, trace_trigger_o, dump_valid_o, dump_last_o, dump_done_o;
  logic [2:0] trace_rd_addr_o, state_o;
  logic [31:0] dump_pc_o, dump_instr_o, trig_pc_o;
  logic [3:0] fill_o;
  int checks = 0, failures = 0;
  always #5 clk_i = ~clk_i;
  trace_capture_ctrl #(.TRACE_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i), .force_trig_i(force_trig_i),
    .pc_match_en_i(pc_match_en_i), .pc_match_i(pc_match_i), .post_count_i(post_count_i),
    .retire_pulse_i(retire_pulse_i), .fetch_pc_i(fetch_pc_i), .buf_wr_ptr_i(buf_wr_ptr_i),
    .buf_rd_pc_i(buf_rd_pc_i), .buf_rd_instr_i(buf_rd_instr_i), .trace_enable_o(trace_enable_o),
    .trace_trigger_o(trace_trigger_o), .trace_rd_addr_o(trace_rd_addr_o), .dump_start_i(dump_start_i),
    .dump_ready_i(dump_ready_i), .dump_valid_o(dump_valid_o), .dump_pc_o(dump_pc_o),
    .dump_instr_o(dump_instr_o), .dump_last_o(dump_last_o), .dump_done_o(dump_done_o),
    .state_o(state_o), .fill_o(fill_o), .trig_pc_o(trig_pc_o)
  );
  // trace buffer stand-in: written whenever the controller enables capture on a retire
  logic [31:0] mem_pc [D];
  logic [31:0] mem_ins [D];
  logic [2:0] wr_ptr = 3'd5;
  always @(posedge clk_i) if (trace_enable_o && retire_pulse_i) begin
    mem_pc[wr_ptr] <= fetch_pc_i;
    mem_ins[wr_ptr] <= instr;
    wr_ptr <= wr_ptr + 3'd1;
  end
  assign buf_wr_ptr_i = wr_ptr;
  assign buf_rd_pc_i = mem_pc[trace_rd_addr_o];
  assign buf_rd_instr_i = mem_ins[trace_rd_addr_o];
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endfunction
  // model: captured entries are a queue of the newest D retires since arm; fill is its size
  int m_state = 0, m_rem = 0, m_idx = 0, m_start = 0;
  bit m_done = 0, m_en;
  logic [31:0] m_tpc = 0;
  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_state = 0; m_rem = 0; m_idx = 0; m_start = 0; m_done = 0; m_tpc = 0;
      q_pc.delete(); q_ins.delete();
    end else begin
      m_en = (m_state == 1) || (m_state == 2 && m_rem != 0);
      m_done = 0;
      if (abort_i) m_state = 0;
      else begin
        if (m_en && retire_pulse_i) begin
          q_pc.push_back(fetch_pc_i);
          q_ins.push_back(instr);
          if (q_pc.size() > D) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
          end
        end
        case (m_state)
          0: if (arm_i) begin m_state = 1; q_pc.delete(); q_ins.delete(); end
          1: if (force_trig_i || (retire_pulse_i && pc_match_en_i && fetch_pc_i == pc_match_i)) begin
            m_state = 2; m_rem = int'(post_count_i); m_tpc = fetch_pc_i;
          end
          2: if (m_rem == 0) m_state = 3; else if (retire_pulse_i) m_rem--;
          3: if (arm_i) begin m_state = 1; q_pc.delete(); q_ins.delete(); end
             else if (dump_start_i) begin
               if (q_pc.size() == 0) m_done = 1;
               else begin m_start = (int'(buf_wr_ptr_i) - q_pc.size() + D) % D; m_idx = 0; m_state = 4; end
             end
          4: m_state = 5;
          5: if (dump_ready_i) begin
            if (m_idx == q_pc.size() - 1) begin m_done = 1; m_state = 3; end
            else begin m_idx++; m_state = 4; end
          end
          default: m_state = 0;
        endcase
      end
    end
  end
  always @(negedge clk_i) begin
    chk("state", 32'(state_o), m_state);
    chk("fill", 32'(fill_o), q_pc.size());
    chk("enable", 32'(trace_enable_o), 32'((m_state == 1) || (m_state == 2 && m_rem != 0)));
    chk("trigger", 32'(trace_trigger_o), 32'(m_state >= 3 && m_state <= 5));
    chk("trig_pc", trig_pc_o, m_tpc);
    chk("valid", 32'(dump_valid_o), 32'(m_state == 5));
    chk("last", 32'(dump_last_o), 32'(m_state == 5 && m_idx == q_pc.size() - 1));
    chk("done", 32'(dump_done_o), 32'(m_done));
    if (m_state == 4) chk("rd_addr", 32'(trace_rd_addr_o), (m_start + m_idx) % D);
    if (m_state == 5) begin
      chk("dump_pc", dump_pc_o, q_pc[m_idx]);
      chk("dump_instr", dump_instr_o, q_ins[m_idx]);
    end
    if (rst_i) begin
      chk("rst_rd_addr", 32'(trace_rd_addr_o), 0);
      chk("rst_dump_data", dump_pc_o | dump_instr_o, 0);
    end
  end
  task automatic tick();
    @(posedge clk_i);
    #2;
    arm_i = 0; abort_i = 0; force_trig_i = 0; retire_pulse_i = 0; dump_start_i = 0;
  endtask
  task automatic ret(input logic [31:0] pc);
    retire_pulse_i = 1; fetch_pc_i = pc; instr = $urandom;
    tick();
  endtask
  task automatic dump(input int stall, output int n, output int lastn, output int dones,
                      output logic [31:0] first, output logic [31:0] lastpc, output logic [2:0] addr0);
    int w;
    bit fin;
    n = 0; lastn = 0; dones = 0; first = 0; lastpc = 0; w = 0; fin = 0;
    dump_ready_i = (stall == 0);
    dump_start_i = 1;
    tick();
    addr0 = trace_rd_addr_o;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (dump_valid_o) begin
        dump_ready_i = (w >= stall);
        w++;
        if (dump_ready_i) begin
          if (n == 0) first = dump_pc_o;
          if (dump_last_o) begin lastpc = dump_pc_o; lastn = n + 1; end
          n++;
          w = 0;
        end
      end
      tick();
      if (dump_done_o) begin dones++; fin = 1; end
    end
    chk("dump_finished", 32'(fin), 1);
    repeat (3) begin tick(); if (dump_done_o) dones++; end
    dump_ready_i = 1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, lastn, dones;
    logic [31:0] first, lastpc;
    logic [2:0] addr0, wp;
    #1 rst_i = 1;
    repeat (2) tick();
    chk("reset_state", 32'(state_o), 0);
    chk("reset_fill", 32'(fill_o), 0);
    rst_i = 0;
    // PC-match trigger with two post-trigger retires
    arm_i = 1; tick();
    pc_match_en_i = 1; pc_match_i = 32'h100; post_count_i = 2;
    ret(32'h200); ret(32'h204); ret(32'h208); ret(32'h100); ret(32'h10c); ret(32'h110);
    tick();
    chk("pcm_state", 32'(state_o), 3);
    chk("pcm_fill", 32'(fill_o), 6);
    chk("pcm_trig_pc", trig_pc_o, 32'h100);
    dump(0, n, lastn, dones, first, lastpc, addr0);
    chk("pcm_count", n, 6);
    chk("pcm_first", first, 32'h200);
    chk("pcm_lastpc", lastpc, 32'h110);
    // saturation and wrap, software trigger with no post capture
    pc_match_en_i = 0;
    arm_i = 1; tick();
    for (int i = 0; i < 12; i++) ret(32'h1000 + 32'(4 * i));
    force_trig_i = 1; post_count_i = 0;
    tick(); tick(); tick();
    chk("sat_state", 32'(state_o), 3);
    chk("sat_fill", 32'(fill_o), 8);
    wp = buf_wr_ptr_i;
    dump(0, n, lastn, dones, first, lastpc, addr0);
    chk("sat_count", n, 8);
    chk("sat_first", first, 32'h1010);
    chk("sat_lastpc", lastpc, 32'h102c);
    chk("sat_last_pos", lastn, 8);
    chk("sat_start_addr", 32'(addr0), 32'(wp));
    // replay with backpressure
    dump(5, n, lastn, dones, first, lastpc, addr0);
    chk("stall_count", n, 8);
    chk("stall_first", first, 32'h1010);
    chk("stall_lastpc", lastpc, 32'h102c);
    chk("stall_done_pulses", dones, 1);
    // simultaneous trigger sources, then abort mid-dump
    arm_i = 1; tick();
    pc_match_en_i = 1; pc_match_i = 32'h300; post_count_i = 3;
    force_trig_i = 1; ret(32'h300);
    chk("dual_state", 32'(state_o), 2);
    chk("dual_trig_pc", trig_pc_o, 32'h300);
    chk("dual_fill", 32'(fill_o), 1);
    ret(32'h304); ret(32'h308);
    chk("dual_enable_mid", 32'(trace_enable_o), 1);
    ret(32'h30c);
    chk("dual_enable_end", 32'(trace_enable_o), 0);
    chk("dual_fill_end", 32'(fill_o), 4);
    tick();
    chk("dual_frozen", 32'(state_o), 3);
    dump_ready_i = 0; dump_start_i = 1; tick(); tick();
    chk("abort_pre_valid", 32'(dump_valid_o), 1);
    abort_i = 1; tick();
    chk("abort_state", 32'(state_o), 0);
    chk("abort_valid", 32'(dump_valid_o), 0);
    dump_ready_i = 1;
    // empty dump
    pc_match_en_i = 0;
    arm_i = 1; tick();
    force_trig_i = 1; post_count_i = 0; tick(); tick();
    chk("empty_state", 32'(state_o), 3);
    dump_start_i = 1; tick();
    chk("empty_done", 32'(dump_done_o), 1);
    chk("empty_valid", 32'(dump_valid_o), 0);
    tick();
    chk("empty_done_off", 32'(dump_done_o), 0);
    // reset in the middle of a dump
    arm_i = 1; tick();
    ret(32'h500); ret(32'h504); ret(32'h508);
    force_trig_i = 1; tick(); tick();
    dump_ready_i = 0; dump_start_i = 1; tick(); tick();
    chk("mid_valid", 32'(dump_valid_o), 1);
    #1 rst_i = 1;
    #1;
    chk("mrst_state", 32'(state_o), 0);
    chk("mrst_fill", 32'(fill_o), 0);
    chk("mrst_trig_pc", trig_pc_o, 0);
    chk("mrst_dump", dump_pc_o | dump_instr_o, 0);
    chk("mrst_bits", 32'({trace_enable_o, trace_trigger_o, dump_valid_o, dump_last_o, dump_done_o, trace_rd_addr_o}), 0);
    tick();
    rst_i = 0; dump_ready_i = 1;
    // randomized traffic
    for (int c = 0; c < 6000; c++) begin
      arm_i = ($urandom_range(0, 49) == 0);
      abort_i = ($urandom_range(0, 299) == 0);
      force_trig_i = ($urandom_range(0, 29) == 0);
      retire_pulse_i = $urandom_range(0, 1) == 1;
      fetch_pc_i = 32'h400 + 32'(4 * $urandom_range(0, 7));
      pc_match_en_i = $urandom_range(0, 1) == 1;
      pc_match_i = 32'h400 + 32'(4 * $urandom_range(0, 7));
      post_count_i = 4'($urandom_range(0, 15));
      dump_start_i = ($urandom_range(0, 5) == 0);
      dump_ready_i = ($urandom_range(0, 2) != 0);
      instr = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        rst_i = 1; tick(); rst_i = 0;
      end else tick();
    end
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 Parameter TRACE_DEPTH, default 64, trace buffer entry count; SHALL be a power of two ≥4; PTR_BITS = log2(TRACE_DEPTH).
REQ-002 clk_i  in  1  clock; reset rst_i, asynchronous, active-high; clock clk_i.
REQ-003 rst_i  in  1  asynchronous active-high reset.
REQ-004 arm_i  in  1  pulse: start new capture.
REQ-005 abort_i  in  1  pulse: return to IDLE from any state.
REQ-006 force_trig_i  in  1  pulse: software trigger.
REQ-007 pc_match_en_i  in  1  enable PC-match trigger; pc_match_i  in  32  trigger PC.
REQ-008 post_count_i  in  PTR_BITS+1  retires to capture after trigger, sampled at trigger.
REQ-009 retire_pulse_i  in  1  retire event; fetch_pc_i  in  32  PC of retiring instruction.
REQ-010 buf_wr_ptr_i  in  PTR_BITS  trace buffer next-write pointer; buf_rd_pc_i, buf_rd_instr_i  in  32 each  combinational buffer read data for trace_rd_addr_o.
REQ-011 trace_enable_o  out  1; trace_trigger_o  out  1 (freeze); trace_rd_addr_o  out  PTR_BITS.
REQ-012 dump_start_i  in  1 pulse; dump_ready_i  in  1.
REQ-013 dump_valid_o  out  1; dump_pc_o, dump_instr_o  out  32 each; dump_last_o  out  1; dump_done_o  out  1 pulse.
REQ-014 state_o  out  3  encoded state; fill_o  out  PTR_BITS+1  valid entries; trig_pc_o  out  32  PC at trigger.

Function
REQ-015 States/encoding SHALL be IDLE=0, ARMED=1, POST=2, FROZEN=3, FETCH=4, SEND=5; state_o reflects current state.
REQ-016 abort_i SHALL force IDLE next cycle from any state, overriding every other input; dump_valid_o low next cycle.
REQ-017 arm_i in IDLE or FROZEN SHALL move to ARMED next cycle and clear fill_o to 0; arm_i in other states SHALL be ignored.
REQ-018 trace_enable_o SHALL be high in ARMED, and in POST while remaining count ≠0; low otherwise.
REQ-019 fill_o SHALL increment on each retire_pulse_i while trace_enable_o high, saturating at TRACE_DEPTH.
REQ-020 Trigger in ARMED: force_trig_i, or retire_pulse_i with pc_match_en_i and fetch_pc_i==pc_match_i; simultaneous sources SHALL yield one trigger.
REQ-021 On trigger: next state POST, remaining ← post_count_i, trig_pc_o ← fetch_pc_i; the triggering retire (if any) SHALL be counted in fill_o.
REQ-022 In POST each retire_pulse_i SHALL decrement remaining; when remaining==0 the next state SHALL be FROZEN (post_count_i=0 → FROZEN two cycles after trigger, no further captures).
REQ-023 trace_trigger_o SHALL be high in FROZEN, FETCH, SEND; low otherwise.
REQ-024 dump_start_i in FROZEN: if fill_o==0, dump_done_o pulses one cycle and stay FROZEN; else latch start = (buf_wr_ptr_i − fill_o) mod TRACE_DEPTH, index ← 0, go FETCH; ignored in other states.
REQ-025 FETCH SHALL drive trace_rd_addr_o = (start+index) mod TRACE_DEPTH, register buf_rd_pc_i/buf_rd_instr_i into dump_pc_o/dump_instr_o, go SEND next cycle.
REQ-026 SEND SHALL hold dump_valid_o high and dump data stable until dump_ready_i; dump_last_o high when index==fill_o−1.
REQ-027 On handshake in SEND: if last, pulse dump_done_o, go FROZEN; else index+1, go FETCH. Throughput one entry per two cycles minimum.
REQ-028 Entries SHALL be dumped oldest to newest; pointer arithmetic wraps modulo TRACE_DEPTH.
REQ-029 A repeated dump_start_i after completion SHALL replay the same entries.

Reset
REQ-030 During rst_i: state IDLE, fill_o=0, remaining=0, trig_pc_o=0, trace_rd_addr_o=0, dump_pc_o/dump_instr_o=0, all single-bit outputs 0.
REQ-031 Reset asserted mid-capture or mid-dump SHALL take effect immediately without completing the transfer.

Verification
REQ-032 DEPTH=8, arm, pc_match=0x100, 3 retires then retire at 0x100, post_count=2, 2 retires -> FROZEN, fill_o=6, trig_pc_o=0x100.
REQ-033 DEPTH=8, arm, 12 retires, force_trig, post_count=0 -> fill_o=8 saturated, dump 8 entries oldest-first starting at buf_wr_ptr_i, dump_last_o on 8th.
REQ-034 Dump with dump_ready_i low 5 cycles per entry -> data/valid stable, no skipped or duplicated entries, dump_done_o one pulse.
REQ-035 force_trig_i and PC match same cycle -> single POST entry, remaining=post_count_i; abort_i in SEND -> IDLE, dump_valid_o low next cycle.
REQ-036 dump_start_i with fill_o=0 -> dump_done_o pulse, no dump_valid_o; rst_i mid-dump -> all outputs at reset values.
